// File: rtl/halt_unit.sv
// Retirement-side halt controller: shadows the return-value register, freezes the
// front end on a retired halt, waits for memory to drain, then raises isHalt.
// Optional drain timeout is enabled with `define HALT_DRAIN_TIMEOUT_EN.
module halt_unit #(
  parameter int RET_REG      = 3,
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_is_halt,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_data,
  input  logic        mem_busy,
  output logic        freeze,
  output logic        isHalt,
  output logic [15:0] ret_val,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t     state;
  logic [7:0] drain_cnt;
  logic       halt_retire;
  logic       drain_done;

  assign halt_retire = (state == RUN) && wb_valid && wb_is_halt;
  // Completion is judged on the counter value before this edge's update.
  assign drain_done  = !mem_busy && (drain_cnt == 8'(DRAIN_CYCLES - 1));

`ifdef HALT_DRAIN_TIMEOUT_EN
  logic [15:0] timeout_cnt;
  logic        timeout_hit;

  assign timeout_hit = (timeout_cnt + 16'd1) == 16'(TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt   <= '0;
      drain_timeout <= 1'b0;
    end else if (halt_retire) begin
      timeout_cnt <= '0;
    end else if (state == DRAIN) begin
      timeout_cnt <= timeout_cnt + 16'd1;
      // Normal completion on the same edge takes priority over the timeout.
      if (!drain_done && timeout_hit) drain_timeout <= 1'b1;
    end
  end
`else
  assign drain_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      freeze    <= 1'b0;
      isHalt    <= 1'b0;
      ret_val   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_retire) begin
            state     <= DRAIN;
            freeze    <= 1'b1;
            drain_cnt <= '0;
          end else if (wb_valid && wb_we && wb_rd != 3'd0 && wb_rd == 3'(RET_REG)) begin
            ret_val <= wb_data;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state  <= HALT;
            isHalt <= 1'b1;
          end
`ifdef HALT_DRAIN_TIMEOUT_EN
          else if (timeout_hit) begin
            state  <= HALT;
            isHalt <= 1'b1;
          end
`endif
          if (mem_busy)                drain_cnt <= '0;
          else if (drain_cnt != 8'hFF) drain_cnt <= drain_cnt + 8'd1;
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_unit.sv
// Self-checking bench for halt_unit: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_halt_unit;
  localparam int DC = 2;
  localparam int TO = 10;
`ifdef HALT_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_is_halt, wb_we, mem_busy;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        freeze, isHalt, drain_timeout;
  logic [15:0] ret_val;

  halt_unit #(.RET_REG(3), .DRAIN_CYCLES(DC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_is_halt(wb_is_halt),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_busy(mem_busy),
    .freeze(freeze), .isHalt(isHalt), .ret_val(ret_val), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: phase flags plus a count of consecutive quiet drain cycles.
  bit          m_drain, m_halted, m_to;
  int          m_quiet, m_dcyc;
  logic [15:0] m_ret;

  task automatic model_reset();
    m_drain = 0; m_halted = 0; m_to = 0; m_quiet = 0; m_dcyc = 0; m_ret = '0;
  endtask

  task automatic model_edge();
    if (!m_drain && !m_halted) begin
      if (wb_valid && wb_is_halt) begin
        m_drain = 1; m_quiet = 0; m_dcyc = 0;
      end else if (wb_valid && wb_we && wb_rd == 3'd3) begin
        m_ret = wb_data;
      end
    end else if (m_drain) begin
      m_dcyc++;
      m_quiet = mem_busy ? 0 : m_quiet + 1;
      if (m_quiet >= DC) begin
        m_drain = 0; m_halted = 1;
      end else if (TO_EN && m_dcyc >= TO) begin
        m_drain = 0; m_halted = 1; m_to = 1;
      end
    end
  endtask

  task automatic drive(input logic v, h, we, input logic [2:0] rd,
                       input logic [15:0] d, input logic busy);
    wb_valid = v; wb_is_halt = h; wb_we = we; wb_rd = rd; wb_data = d; mem_busy = busy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 16'h0, 0);
  endtask

  // One clock: inputs already driven; sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse away from any clock edge, with immediate output check.
  task automatic pulse_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    check({tag, "_rst_freeze"}, {15'd0, freeze}, 16'd0);
    check({tag, "_rst_ishalt"}, {15'd0, isHalt}, 16'd0);
    check({tag, "_rst_ret"}, ret_val, 16'd0);
    check({tag, "_rst_to"}, {15'd0, drain_timeout}, 16'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v, h, we;
    logic [2:0]  rd;
    logic [15:0] d;
    logic        busy;
    logic        ef, eh;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[9];
  bit   seen_halt;

  initial begin
    tbl[0] = '{1, 0, 1, 3'd3, 16'h0001, 0, 0, 0, 16'h0001};
    tbl[1] = '{1, 0, 1, 3'd2, 16'h9999, 0, 0, 0, 16'h0001};
    tbl[2] = '{1, 0, 1, 3'd0, 16'h7777, 0, 0, 0, 16'h0001};
    tbl[3] = '{0, 0, 1, 3'd3, 16'h3333, 0, 0, 0, 16'h0001};
    tbl[4] = '{1, 1, 1, 3'd3, 16'hBEEF, 0, 1, 0, 16'h0001};
    tbl[5] = '{0, 0, 0, 3'd0, 16'h0000, 0, 1, 0, 16'h0001};
    tbl[6] = '{0, 0, 0, 3'd0, 16'h0000, 0, 1, 1, 16'h0001};
    tbl[7] = '{1, 1, 1, 3'd3, 16'h5555, 1, 1, 1, 16'h0001};
    tbl[8] = '{1, 0, 1, 3'd3, 16'h6666, 1, 1, 1, 16'h0001};

    idle();
    rst_n = 1'b0;
    #12;
    model_reset();
    check("init_freeze", {15'd0, freeze}, 16'd0);
    check("init_ishalt", {15'd0, isHalt}, 16'd0);
    check("init_ret", ret_val, 16'd0);
    check("init_to", {15'd0, drain_timeout}, 16'd0);
    rst_n = 1'b1;

    // Vector table: shadow filtering, halt with wb_we ignored, drain, HALT inertness.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].h, tbl[i].we, tbl[i].rd, tbl[i].d, tbl[i].busy);
      step();
      check($sformatf("vec%0d_freeze", i), {15'd0, freeze}, {15'd0, tbl[i].ef});
      check($sformatf("vec%0d_ishalt", i), {15'd0, isHalt}, {15'd0, tbl[i].eh});
      check($sformatf("vec%0d_ret", i), ret_val, tbl[i].er);
    end

    // Write r3 at edge 5, halt at edge 8, isHalt after edge 10.
    pulse_reset("seq1");
    for (int e = 1; e <= 10; e++) begin
      if (e == 5)      drive(1, 0, 1, 3'd3, 16'h0042, 0);
      else if (e == 8) drive(1, 1, 0, 3'd0, 16'h0000, 0);
      else             idle();
      step();
      if (e == 8) check("seq1_freeze_e8", {15'd0, freeze}, 16'd1);
      if (e == 9) check("seq1_ishalt_e9", {15'd0, isHalt}, 16'd0);
    end
    check("seq1_ishalt_e10", {15'd0, isHalt}, 16'd1);
    check("seq1_ret", ret_val, 16'h0042);

    // mem_busy at T+1..T+4 restarts drain; r3 write at T+2 ignored.
    pulse_reset("seq3");
    drive(1, 0, 1, 3'd3, 16'h1234, 0); step();
    drive(1, 1, 0, 3'd0, 16'h0000, 0); step();
    for (int k = 1; k <= 6; k++) begin
      if (k == 2)      drive(1, 0, 1, 3'd3, 16'hAAAA, 1);
      else if (k <= 4) drive(0, 0, 0, 3'd0, 16'h0000, 1);
      else             idle();
      step();
      if (k == 5) check("seq3_ishalt_t5", {15'd0, isHalt}, 16'd0);
    end
    check("seq3_ishalt_t6", {15'd0, isHalt}, 16'd1);
    check("seq3_ret", ret_val, 16'h1234);

    // In HALT: further halts and r3 writes change nothing; then async reset mid-HALT.
    drive(1, 1, 1, 3'd3, 16'hCAFE, 0); step(); step();
    drive(1, 0, 1, 3'd3, 16'hD00D, 1); step();
    check("seq4_ishalt_hold", {15'd0, isHalt}, 16'd1);
    check("seq4_freeze_hold", {15'd0, freeze}, 16'd1);
    check("seq4_ret_hold", ret_val, 16'h1234);
    pulse_reset("seq4");

    // Reset one cycle before drain completion, then a clean post-reset halt.
    drive(1, 0, 1, 3'd3, 16'h0F0F, 0); step();
    drive(1, 1, 0, 3'd0, 16'h0000, 0); step();
    idle(); step();
    check("seq6_pre_ishalt", {15'd0, isHalt}, 16'd0);
    pulse_reset("seq6");
    step(); step();
    check("seq6_run_freeze", {15'd0, freeze}, 16'd0);
    check("seq6_run_ishalt", {15'd0, isHalt}, 16'd0);
    drive(1, 0, 1, 3'd3, 16'h0077, 0); step();
    drive(1, 1, 0, 3'd0, 16'h0000, 0); step();
    idle(); step(); step();
    check("seq6_ishalt", {15'd0, isHalt}, 16'd1);
    check("seq6_ret", ret_val, 16'h0077);

    // Permanent mem_busy: timeout after TO cycles, or wait forever without it.
    pulse_reset("seq5");
    drive(1, 1, 0, 3'd0, 16'h0000, 1); step();
    drive(0, 0, 0, 3'd0, 16'h0000, 1);
    seen_halt = 0;
    for (int k = 1; k <= (TO_EN ? TO : 500); k++) begin
      step();
      if (k == TO - 1) check("seq5_ishalt_before", {15'd0, isHalt}, 16'd0);
      if (k < (TO_EN ? TO : 501) && isHalt) seen_halt = 1;
    end
    check("seq5_early_halt", {15'd0, 7'd0, seen_halt}, 16'd0);
    check("seq5_ishalt_end", {15'd0, isHalt}, {15'd0, TO_EN});
    check("seq5_to_end", {15'd0, drain_timeout}, {15'd0, TO_EN});

    // Randomized traffic against the behavioural model, with periodic resets.
    pulse_reset("rnd");
    for (int c = 0; c < 600; c++) begin
      if ((m_halted && $urandom_range(7) == 0) || $urandom_range(99) == 0) begin
        pulse_reset($sformatf("rnd%0d", c));
      end else begin
        drive($urandom_range(3) != 0, $urandom_range(11) == 0, 1'($urandom),
              3'($urandom), 16'($urandom), $urandom_range(2) == 0);
        step();
        check($sformatf("rnd%0d_freeze", c), {15'd0, freeze}, {15'd0, m_drain | m_halted});
        check($sformatf("rnd%0d_ishalt", c), {15'd0, isHalt}, {15'd0, m_halted});
        check($sformatf("rnd%0d_ret", c), ret_val, m_ret);
        check($sformatf("rnd%0d_to", c), {15'd0, drain_timeout}, {15'd0, m_to});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
